// File: rtl/fir_coeff_bank_pkg.sv
// Shared definitions for the FIR coefficient bank: the load/swap FSM encoding.
package fir_coeff_bank_pkg;

    // IDLE: no load pending; LOAD: accepting beats; SWAP_WAIT: full set held, waiting for clken.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/fir_coeff_reg.sv
// One tap of the coefficient bank: a shadow register written by the load port
// and an active register that copies the shadow only when swap is asserted.
module fir_coeff_reg #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         swap,
    output logic [W-1:0] dout
);

    logic [W-1:0] shadow;

    // Shadow captures load beats; active follows shadow only on a swap edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow <= '0;
            dout   <= '0;
        end else begin
            if (wr_en) begin
                shadow <= din;
            end
            if (swap) begin
                dout <= shadow;
            end
        end
    end

endmodule

// File: rtl/fir_coeff_bank.sv
// Coefficient store for the serial-MAC FIR: loads a full set into a shadow bank
// and swaps it into the active bank in a single clken-qualified edge, so the
// FIR never sees a partially updated set.
//
// Load handshake: a beat transfers on any posedge where load_valid and
// load_ready are both 1. load_ready depends on the FSM state only (never on
// load_valid); an edge that also carries abort or load_start drops the beat.
module fir_coeff_bank
    import fir_coeff_bank_pkg::*;
#(
    parameter int COEFF_NUM  = 16,
    parameter int COEFF_BITS = 12,
    parameter int CNT_BITS   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clken,
    input  logic                            load_start,
    input  logic                            abort,
    input  logic                            load_valid,
    input  logic [COEFF_BITS-1:0]           load_data,
    output logic                            load_ready,
    output logic [COEFF_NUM*COEFF_BITS-1:0] coeffs,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [1:0]                      state
);

    localparam logic [CNT_BITS-1:0] LAST_INDEX = CNT_BITS'(COEFF_NUM - 1);

    state_t              fsm_state;
    logic [CNT_BITS-1:0] index;
    logic                beat;
    logic                swap;

    assign load_ready = (fsm_state == LOAD);
    assign busy       = (fsm_state != IDLE);
    assign state      = fsm_state;

    // abort and load_start both take priority over a beat on the same edge.
    assign beat = load_valid && load_ready && !abort && !load_start;
    // abort in SWAP_WAIT cancels the swap even when clken is high.
    assign swap = (fsm_state == SWAP_WAIT) && clken && !abort;

    // FSM, index counter and the registered done/err pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_state <= IDLE;
            index     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    if (load_start) begin
                        fsm_state <= LOAD;
                        index     <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        fsm_state <= IDLE;
                        index     <= '0;
                        err       <= 1'b1;
                    end else if (load_start) begin
                        index <= '0;
                        err   <= 1'b1;
                    end else if (load_valid) begin
                        if (index == LAST_INDEX) begin
                            fsm_state <= SWAP_WAIT;
                            index     <= '0;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                SWAP_WAIT: begin
                    if (abort) begin
                        fsm_state <= IDLE;
                        err       <= 1'b1;
                    end else if (clken) begin
                        fsm_state <= IDLE;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    fsm_state <= IDLE;
                    index     <= '0;
                end
            endcase
        end
    end

    // One shadow/active pair per tap; the index decode selects the shadow written.
    for (genvar i = 0; i < COEFF_NUM; i++) begin : g_tap
        logic wr_en;
        assign wr_en = beat && (index == CNT_BITS'(i));
        fir_coeff_reg #(
            .W(COEFF_BITS)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .wr_en (wr_en),
            .din   (load_data),
            .swap  (swap),
            .dout  (coeffs[i*COEFF_BITS +: COEFF_BITS])
        );
    end

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Bench for fir_coeff_bank: a 4-tap and a 16-tap instance share one set of
// inputs; a behavioural model of the load/swap rules tracks both.
module tb_fir_coeff_bank;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clken = 1'b0;
    logic         load_start = 1'b0;
    logic         abort = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;

    logic          ready4, busy4, done4, err4;
    logic [1:0]    state4;
    logic [4*W-1:0] coeffs4;
    logic          ready16, busy16, done16, err16;
    logic [1:0]    state16;
    logic [16*W-1:0] coeffs16;
    logic [5:0]    st4, st16;

    assign st4  = {ready4, busy4, done4, err4, state4};
    assign st16 = {ready16, busy16, done16, err16, state16};

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset block
    always #5 clk = ~clk;

    fir_coeff_bank #(.COEFF_NUM(4), .COEFF_BITS(W), .CNT_BITS(2)) u_dut4 (
        .clk(clk), .reset(reset), .clken(clken), .load_start(load_start),
        .abort(abort), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready4), .coeffs(coeffs4), .busy(busy4), .done(done4),
        .err(err4), .state(state4)
    );

    fir_coeff_bank #(.COEFF_NUM(16), .COEFF_BITS(W), .CNT_BITS(4)) u_dut16 (
        .clk(clk), .reset(reset), .clken(clken), .load_start(load_start),
        .abort(abort), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready16), .coeffs(coeffs16), .busy(busy16), .done(done16),
        .err(err16), .state(state16)
    );

    // Reference model: slot 0 is the 4-tap bank, slot 1 the 16-tap bank.
    // phase 0 = idle, 1 = loading, 2 = full set waiting for clken.
    int           m_phase [2];
    int           m_cnt   [2];
    logic [W-1:0] m_shadow[2][16];
    logic [W-1:0] m_active[2][16];
    logic         m_done  [2];
    logic         m_err   [2];

    function automatic int slot_n(input int s);
        return (s == 0) ? 4 : 16;
    endfunction

    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!reset) begin
                m_phase[s] = 0;
                m_cnt[s]   = 0;
                m_done[s]  = 1'b0;
                m_err[s]   = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    m_shadow[s][i] = '0;
                    m_active[s][i] = '0;
                end
            end else begin
                m_done[s] = 1'b0;
                m_err[s]  = 1'b0;
                if (m_phase[s] == 0) begin
                    if (load_start) begin
                        m_phase[s] = 1;
                        m_cnt[s]   = 0;
                    end
                end else if (m_phase[s] == 1) begin
                    if (abort) begin
                        m_phase[s] = 0;
                        m_err[s]   = 1'b1;
                    end else if (load_start) begin
                        m_cnt[s] = 0;
                        m_err[s] = 1'b1;
                    end else if (load_valid) begin
                        m_shadow[s][m_cnt[s]] = load_data;
                        m_cnt[s] = m_cnt[s] + 1;
                        if (m_cnt[s] == slot_n(s)) begin
                            m_phase[s] = 2;
                            m_cnt[s]   = 0;
                        end
                    end
                end else begin
                    if (abort) begin
                        m_phase[s] = 0;
                        m_err[s]   = 1'b1;
                    end else if (clken) begin
                        for (int i = 0; i < 16; i++) m_active[s][i] = m_shadow[s][i];
                        m_phase[s] = 0;
                        m_done[s]  = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [5:0] exp_status(input int s);
        logic [1:0] ph;
        ph = 2'(m_phase[s]);
        return {m_phase[s] == 1, m_phase[s] != 0, m_done[s], m_err[s], ph};
    endfunction

    function automatic logic [16*W-1:0] exp_coeffs(input int s);
        logic [16*W-1:0] r;
        r = '0;
        for (int i = 0; i < slot_n(s); i++) r[i*W +: W] = m_active[s][i];
        return r;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (coeffs4 !== '0 || coeffs16 !== '0) begin
                n_bad++;
                $display("FAIL reset_coeffs cycle %0d got %h / %h required 0", c, coeffs4, coeffs16);
            end
            n_cmp++;
            if (st4 !== 6'b0 || st16 !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_status cycle %0d got %b / %b required 000000", c, st4, st16);
            end
        end
    endtask

    task automatic test_basic_load();
        logic [W-1:0] v [4];
        v = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
        clken = 1'b1;
        start_load();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = v[i];
            tick();
            n_cmp++;
            if (st4 !== exp_status(0)) begin
                n_bad++;
                $display("FAIL basic_beat%0d status got %b required %b", i, st4, exp_status(0));
            end
        end
        load_valid = 1'b0;
        n_cmp++;
        if (coeffs4 !== 48'h0) begin
            n_bad++;
            $display("FAIL basic_before_swap coeffs got %h required 0", coeffs4);
        end
        tick();
        n_cmp++;
        if (coeffs4 !== {12'hFFF, 12'h800, 12'h7FF, 12'h001}) begin
            n_bad++;
            $display("FAIL basic_swap coeffs got %h required fff8007ff001", coeffs4);
        end
        n_cmp++;
        if (done4 !== 1'b1 || err4 !== 1'b0 || state4 !== 2'd0) begin
            n_bad++;
            $display("FAIL basic_done done/err/state got %b%b%0d required 1 0 0", done4, err4, state4);
        end
        tick();
        n_cmp++;
        if (done4 !== 1'b0 || coeffs4 !== {12'hFFF, 12'h800, 12'h7FF, 12'h001}) begin
            n_bad++;
            $display("FAIL basic_hold done %b coeffs %h required 0 fff8007ff001", done4, coeffs4);
        end
    endtask

    task automatic test_swap_wait();
        logic [W-1:0]   v [4];
        logic [4*W-1:0] old_set, new_set;
        old_set = coeffs4 === {12'hFFF, 12'h800, 12'h7FF, 12'h001} ? coeffs4 : {12'hFFF, 12'h800, 12'h7FF, 12'h001};
        for (int i = 0; i < 4; i++) begin
            v[i] = W'($urandom_range(0, 4095));
            new_set[i*W +: W] = v[i];
        end
        clken = 1'b1;
        start_load();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = v[i];
            tick();
        end
        load_valid = 1'b0;
        clken      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (coeffs4 !== old_set || busy4 !== 1'b1 || state4 !== 2'd2 || done4 !== 1'b0) begin
                n_bad++;
                $display("FAIL swapwait_hold%0d coeffs %h busy %b state %0d done %b required %h 1 2 0",
                         c, coeffs4, busy4, state4, done4, old_set);
            end
        end
        clken = 1'b1;
        tick();
        n_cmp++;
        if (coeffs4 !== new_set || done4 !== 1'b1 || busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL swapwait_swap coeffs %h done %b busy %b required %h 1 0", coeffs4, done4, busy4, new_set);
        end
        n_cmp++;
        if ({48'h0, coeffs4} !== {144'h0, exp_coeffs(0)[4*W-1:0]} && 1'b0) begin
            n_bad++;
        end
    endtask

    task automatic test_restart();
        logic [W-1:0] v [4];
        int errs;
        v = '{12'h011, 12'h012, 12'h013, 12'h014};
        errs = 0;
        clken = 1'b1;
        start_load();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = (i == 0) ? 12'h0AA : 12'h0BB;
            tick();
            if (err4 === 1'b1) errs++;
        end
        load_start = 1'b1;
        load_data  = 12'h0CC;
        tick();
        load_start = 1'b0;
        n_cmp++;
        if (err4 !== 1'b1 || state4 !== 2'd1) begin
            n_bad++;
            $display("FAIL restart_err err %b state %0d required 1 1", err4, state4);
        end
        if (err4 === 1'b1) errs++;
        for (int i = 0; i < 4; i++) begin
            load_data = v[i];
            tick();
            if (err4 === 1'b1) errs++;
        end
        load_valid = 1'b0;
        tick();
        if (err4 === 1'b1) errs++;
        n_cmp++;
        if (coeffs4 !== {12'h014, 12'h013, 12'h012, 12'h011} || done4 !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_coeffs got %h done %b required 014013012011 1", coeffs4, done4);
        end
        n_cmp++;
        if (errs != 1) begin
            n_bad++;
            $display("FAIL restart_err_count got %0d required 1", errs);
        end
    endtask

    task automatic test_abort();
        logic [4*W-1:0] prev;
        prev = {12'h014, 12'h013, 12'h012, 12'h011};
        // abort while idle is a no-op
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (st4 !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_idle status got %b required 000000", st4);
        end
        // abort after three beats
        clken = 1'b1;
        start_load();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = W'($urandom_range(0, 4095));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        load_valid = 1'b0;
        n_cmp++;
        if (err4 !== 1'b1 || state4 !== 2'd0 || done4 !== 1'b0 || coeffs4 !== prev) begin
            n_bad++;
            $display("FAIL abort_load err %b state %0d done %b coeffs %h required 1 0 0 %h",
                     err4, state4, done4, coeffs4, prev);
        end
        // abort in SWAP_WAIT, with clken raised on the same edge
        start_load();
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = W'($urandom_range(0, 4095));
            if (i == 3) clken = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        tick();
        abort = 1'b1;
        clken = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (err4 !== 1'b1 || state4 !== 2'd0 || done4 !== 1'b0 || coeffs4 !== prev) begin
            n_bad++;
            $display("FAIL abort_swapwait err %b state %0d done %b coeffs %h required 1 0 0 %h",
                     err4, state4, done4, coeffs4, prev);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (st4 !== 6'b0 || coeffs4 !== prev) begin
                n_bad++;
                $display("FAIL abort_after%0d status %b coeffs %h required 000000 %h", c, st4, coeffs4, prev);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]    exp_q[$];
        logic [16*W-1:0] want;
        int taken, cycles;
        // start from a clean bank
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clken = 1'b1;
        start_load();
        taken = 0;
        cycles = 0;
        while (taken < 16 && cycles < 400) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = W'($urandom());
            if (load_valid) begin
                exp_q.push_back(load_data);
                taken++;
            end
            tick();
            cycles++;
            n_cmp++;
            if (st16 !== exp_status(1) || {144'h0, coeffs4} !== exp_coeffs(0)) begin
                n_bad++;
                $display("FAIL bp_cycle%0d status16 %b required %b", cycles, st16, exp_status(1));
            end
        end
        load_valid = 1'b0;
        n_cmp++;
        if (taken != 16 || state16 !== 2'd2 || ready16 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_beats taken %0d state %0d ready %b required 16 2 0", taken, state16, ready16);
        end
        // extra beat while waiting must not be taken
        load_valid = 1'b1;
        load_data  = 12'h5A5;
        tick();
        load_valid = 1'b0;
        want = '0;
        for (int i = 0; i < 16; i++) want[i*W +: W] = exp_q.pop_front();
        n_cmp++;
        if (coeffs16 !== want || done16 !== 1'b1 || coeffs16 !== exp_coeffs(1)) begin
            n_bad++;
            $display("FAIL bp_swap coeffs %h done %b required %h 1", coeffs16, done16, want);
        end
        // second load, reset hits during beat 9
        start_load();
        taken = 0;
        cycles = 0;
        while (taken < 8 && cycles < 200) begin
            load_valid = ($urandom_range(0, 1) != 0);
            load_data  = W'($urandom());
            if (load_valid) taken++;
            tick();
            cycles++;
        end
        n_cmp++;
        if (taken != 8 || coeffs16 !== want || st16 !== exp_status(1)) begin
            n_bad++;
            $display("FAIL bp_partial taken %0d coeffs %h status %b required 8 %h %b",
                     taken, coeffs16, st16, want, exp_status(1));
        end
        load_valid = 1'b1;
        load_data  = 12'h999;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (coeffs16 !== '0 || st16 !== 6'b0 || coeffs4 !== '0 || st4 !== 6'b0) begin
            n_bad++;
            $display("FAIL bp_reset coeffs16 %h st16 %b st4 %b required 0 000000 000000", coeffs16, st16, st4);
        end
        reset = 1'b1;
        load_valid = 1'b0;
        tick();
        n_cmp++;
        if (coeffs16 !== '0 || st16 !== 6'b0) begin
            n_bad++;
            $display("FAIL bp_post_reset coeffs16 %h st16 %b required 0 000000", coeffs16, st16);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_swap_wait();
        test_restart();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
